// File: rtl/clac_ahb_slv_if.sv
// clac_ahb_slv_if: AHB-Lite slave-side bus bundle for the clac front-end.
// Revision: 1.0
`default_nettype none

interface clac_ahb_slv_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

`default_nettype wire

// File: rtl/clac_ahb_slv.sv
// clac_ahb_slv: AHB-Lite register front-end driving the clac ALU and capturing its result.
// Revision: 1.0
`default_nettype none

module clac_ahb_slv (
  input  logic               hclk,
  input  logic               hrst,
  clac_ahb_slv_if.slave      bus,
  output logic               ctrl,
  output logic [1:0]         clac_mode,
  output logic [15:0]        opcode_a,
  output logic [15:0]        opcode_b,
  input  logic [31:0]        result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_OPA  = 3'd1;
  localparam logic [2:0] A_OPB  = 3'd2;
  localparam logic [2:0] A_RES  = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;

  state_t      state, state_nxt;
  logic        dp_valid, dp_write, dp_err, err_2nd;
  logic [2:0]  dp_addr;
  logic [1:0]  mode_q;
  logic [15:0] opa_q, opb_q;
  logic [31:0] res_q;
  logic [31:0] rd_mux;

  logic accept, addr_bad, stall, err_1st, done_ok, wr_ok, rd_ok, start;
  logic unused_ok;

  assign accept   = bus.hsel & bus.hready & bus.htrans[1];
  assign addr_bad = (bus.haddr[4:2] > A_STAT) | (bus.haddr[1:0] != 2'b00);

  // Data phases that touch state being updated by the capture wait one cycle.
  assign stall   = dp_valid & ~dp_err & (state == CALC) &
                   (dp_write | (dp_addr == A_RES) | (dp_addr == A_STAT));
  assign err_1st = dp_valid & dp_err & ~err_2nd;
  assign done_ok = dp_valid & ~dp_err & ~stall;
  assign wr_ok   = done_ok & dp_write;
  assign rd_ok   = done_ok & ~dp_write;
  assign start   = wr_ok & (dp_addr == A_CTRL) & bus.hwdata[0];

  assign bus.hreadyout = ~(stall | err_1st);
  assign bus.hresp     = dp_valid & dp_err;

  assign unused_ok = ^{bus.hsize, bus.haddr[31:5], bus.htrans[0], bus.hwdata[31:16]};

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_err   <= 1'b0;
      dp_addr  <= 3'd0;
      err_2nd  <= 1'b0;
    end else begin
      err_2nd <= err_1st;
      if (bus.hready) begin
        dp_valid <= accept;
        dp_write <= bus.hwrite;
        dp_err   <= addr_bad;
        dp_addr  <= bus.haddr[4:2];
      end
    end
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      mode_q <= 2'd0;
      opa_q  <= 16'd0;
      opb_q  <= 16'd0;
      res_q  <= 32'd0;
      state  <= IDLE;
    end else begin
      state <= state_nxt;
      if (state == CALC) begin
        res_q <= result;
      end
      if (wr_ok) begin
        case (dp_addr)
          A_CTRL:  mode_q <= bus.hwdata[2:1];
          A_OPA:   opa_q  <= bus.hwdata[15:0];
          A_OPB:   opb_q  <= bus.hwdata[15:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        ctrl      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (start)
          state_nxt = CALC;
        else if (rd_ok && (dp_addr == A_RES))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    case (dp_addr)
      A_CTRL:  rd_mux = {29'd0, mode_q, 1'b0};
      A_OPA:   rd_mux = {16'd0, opa_q};
      A_OPB:   rd_mux = {16'd0, opb_q};
      A_RES:   rd_mux = res_q;
      A_STAT:  rd_mux = {30'd0, (state == DONE), (state == CALC)};
      default: rd_mux = 32'd0;
    endcase
  end

  assign bus.hrdata = (dp_valid & ~dp_write & ~dp_err) ? rd_mux : 32'd0;

  assign clac_mode = mode_q;
  assign opcode_a  = opa_q;
  assign opcode_b  = opb_q;

endmodule

`default_nettype wire

// File: tb/tb_clac_ahb_slv.sv
// tb_clac_ahb_slv: directed plus randomized bus traffic checked against a register-level model.
// Revision: 1.0
`default_nettype none

module tb_clac_ahb_slv;

  logic        hclk = 1'b0;
  logic        hrst = 1'b1;
  logic        ctrl;
  logic [1:0]  clac_mode;
  logic [15:0] opcode_a, opcode_b;
  logic [31:0] result;

  always #5 hclk = ~hclk;

  clac_ahb_slv_if bus ();

  function automatic logic [31:0] clac_f(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    case (m)
      2'd0:    return {16'd0, a & b};
      2'd1:    return {16'd0, a | b};
      2'd2:    return {16'd0, a ^ b};
      default: return 32'(a) + 32'(b);
    endcase
  endfunction

  assign bus.hready = bus.hreadyout;
  assign result     = clac_f(clac_mode, opcode_a, opcode_b);

  clac_ahb_slv dut (
    .hclk      (hclk),
    .hrst      (hrst),
    .bus       (bus),
    .ctrl      (ctrl),
    .clac_mode (clac_mode),
    .opcode_a  (opcode_a),
    .opcode_b  (opcode_b),
    .result    (result)
  );

  int n_chk = 0;
  int n_pass = 0;
  int ctrl_cnt = 0;

  always @(negedge hclk) if (ctrl === 1'b1) ctrl_cnt++;

  // Register-level model of the slave.
  logic [1:0]  m_mode = 2'd0;
  logic [15:0] m_a = 16'd0, m_b = 16'd0;
  logic [31:0] m_res = 32'd0;
  bit          m_done = 1'b0;
  int          m_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[4:0] <= 5'h10) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_rd(input logic [2:0] idx);
    case (idx)
      3'd0:    return {29'd0, m_mode, 1'b0};
      3'd1:    return {16'd0, m_a};
      3'd2:    return {16'd0, m_b};
      3'd3:    return m_res;
      3'd4:    return {30'd0, m_done, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_wr(input logic [2:0] idx, input logic [31:0] d);
    case (idx)
      3'd0: begin
        m_mode = d[2:1];
        if (d[0]) begin
          m_res = clac_f(m_mode, m_a, m_b);
          m_done = 1'b1;
          m_pulses++;
        end
      end
      3'd1: m_a = d[15:0];
      3'd2: m_b = d[15:0];
      default: ;
    endcase
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic resp, output logic first_resp,
                      output int waits);
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = wr; bus.haddr = addr; bus.hsize = 3'b010;
    @(posedge hclk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = wdata;
    waits = 0;
    first_resp = 1'b0;
    forever begin
      @(negedge hclk);
      if (waits == 0) first_resp = bus.hresp;
      if (bus.hreadyout) break;
      waits++;
      if (waits > 8) begin
        check("timeout", 32'(waits), 32'd0);
        break;
      end
    end
    rdata = bus.hrdata;
    resp  = bus.hresp;
    @(posedge hclk); #1;
  endtask

  task automatic chk_err(input logic resp, input logic first_resp, input int waits);
    check("err_resp1", 32'(first_resp), 32'd1);
    check("err_waits", 32'(waits), 32'd1);
    check("err_resp2", 32'(resp), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] rd;
    logic resp, fr;
    int w;
    xfer(1'b1, addr, d, rd, resp, fr, w);
    if (legal(addr)) begin
      check("wr_resp", 32'(resp), 32'd0);
      check("wr_waits", 32'(w), 32'd0);
      model_wr(addr[4:2], d);
    end else begin
      chk_err(resp, fr, w);
    end
    // Let any started calculation finish before the next check.
    @(posedge hclk); #1;
    check("ctrl_pulses", 32'(ctrl_cnt), 32'(m_pulses));
  endtask

  task automatic do_read(input logic [31:0] addr);
    logic [31:0] rd;
    logic resp, fr;
    int w;
    xfer(1'b0, addr, 32'd0, rd, resp, fr, w);
    if (legal(addr)) begin
      check("rd_resp", 32'(resp), 32'd0);
      check("rd_waits", 32'(w), 32'd0);
      check($sformatf("rd_%0h", addr[4:0]), rd, model_rd(addr[4:2]));
      if (addr[4:2] == 3'd3) m_done = 1'b0;
    end else begin
      chk_err(resp, fr, w);
      check("err_rdata", rd, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    bus.hsel = 1'b0; bus.haddr = 32'd0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
    bus.hsize = 3'b010; bus.hwdata = 32'd0;
    repeat (3) @(posedge hclk);
    #1;
    check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("rst_hresp", 32'(bus.hresp), 32'd0);
    check("rst_hrdata", bus.hrdata, 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_outs", {clac_mode, opcode_a, opcode_b[13:0]}, 32'd0);
    hrst = 1'b0;

    // AND example, STATUS before/after the RESULT read.
    do_write(32'h04, 32'h00FF);
    do_write(32'h08, 32'h0F0F);
    do_write(32'h00, 32'h1);
    do_read(32'h10);
    do_read(32'h0C);
    do_read(32'h10);

    // ADD then XOR.
    do_write(32'h04, 32'hFFFF);
    do_write(32'h08, 32'h0001);
    do_write(32'h00, 32'h7);
    do_read(32'h0C);
    do_write(32'h00, 32'h5);
    do_read(32'h0C);

    // START write immediately followed by a STATUS read.
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = 32'h00;
    @(posedge hclk); #1;
    bus.hwdata = 32'h3; bus.hwrite = 1'b0; bus.haddr = 32'h10;
    model_wr(3'd0, 32'h3);
    @(negedge hclk);
    check("b2b_wr_ready", 32'(bus.hreadyout), 32'd1);
    @(posedge hclk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    @(negedge hclk);
    check("b2b_wait", 32'(bus.hreadyout), 32'd0);
    check("b2b_ctrl", 32'(ctrl), 32'd1);
    @(negedge hclk);
    check("b2b_ready", 32'(bus.hreadyout), 32'd1);
    check("b2b_resp", 32'(bus.hresp), 32'd0);
    check("b2b_status", bus.hrdata, model_rd(3'd4));
    @(posedge hclk); #1;
    do_read(32'h0C);

    // Illegal accesses leave registers unchanged.
    do_read(32'h14);
    do_write(32'h06, 32'hFFFF_FFFF);
    do_read(32'h00);
    do_read(32'h04);
    do_read(32'h08);

    // Reset during the CALC cycle.
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = 32'h00;
    @(posedge hclk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = 32'h3;
    @(posedge hclk); #1;
    check("calc_ctrl", 32'(ctrl), 32'd1);
    hrst = 1'b1;
    #1;
    check("mid_rst_ctrl", 32'(ctrl), 32'd0);
    check("mid_rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("mid_rst_hresp", 32'(bus.hresp), 32'd0);
    check("mid_rst_hrdata", bus.hrdata, 32'd0);
    check("mid_rst_outs", {clac_mode, opcode_a, opcode_b[13:0]}, 32'd0);
    m_mode = 2'd0; m_a = 16'd0; m_b = 16'd0; m_res = 32'd0; m_done = 1'b0;
    @(posedge hclk); #1;
    hrst = 1'b0;
    do_read(32'h0C);
    do_read(32'h10);

    // RESULT is read-only.
    do_write(32'h04, 32'h1234);
    do_write(32'h00, 32'h1);
    do_write(32'h0C, 32'hABCD);
    do_read(32'h0C);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      a = {27'($urandom), 5'd0};
      case ($urandom_range(0, 9))
        0, 1: do_write(a | {27'd0, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd2, 2'b00}, $urandom);
        2, 3: do_write(a, $urandom & 32'h7);
        4, 5, 6, 7: do_read(a | {27'd0, 3'($urandom_range(0, 4)), 2'b00});
        8: begin
          if ($urandom_range(0, 1) != 0)
            a = a | {27'd0, 3'($urandom_range(5, 7)), 2'($urandom)};
          else
            a = a | {27'd0, 3'($urandom_range(0, 4)), 2'($urandom_range(1, 3))};
          if ($urandom_range(0, 1) != 0) do_write(a, $urandom);
          else do_read(a);
        end
        default: do_write(a | {27'd0, 3'($urandom_range(3, 4)), 2'b00}, $urandom);
      endcase
    end
    check("final_pulses", 32'(ctrl_cnt), 32'(m_pulses));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clac_ahb_slv.md
# clac_ahb_slv

AHB-Lite slave front-end for the `clac` arithmetic/logic unit. The bus master writes the operands and mode into registers, starts an operation through a CTRL write, and reads back the captured 32-bit result and status. The block drives the `clac` input side (ctrl, mode, operands) and samples its `result`. It is the bus-facing end of that interface and sits between the AHB interconnect and the `clac` instance.

## Interface
- No parameters. Register offsets are fixed; address decode uses `haddr[4:0]`.
- `hclk` in 1: clock; all state updates on the rising edge.
- `hrst` in 1: reset; asynchronous, active-high.
- `hsel` in 1: slave select.
- `haddr` in 32: address. Only bits [4:0] are decoded.
- `htrans` in 2: transfer type. Only NONSEQ (2'b10) and SEQ (2'b11) are active.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size. Ignored; every access is treated as 32-bit.
- `hwdata` in 32: write data, valid in the data phase.
- `hready` in 1: bus ready. An address phase is accepted only when `hsel & hready & htrans[1]`.
- `hreadyout` out 1: slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out 32: read data.
- `ctrl` out 1: calc enable to `clac`.
- `clac_mode` out 2: 00 AND, 01 OR, 10 XOR, 11 ADD.
- `opcode_a`, `opcode_b` out 16 each: operands.
- `result` in 32: combinational result from `clac`.

## Operation
Register map (word offsets):
- 0x00 CTRL, RW: bit0 START (write-1 pulse, reads 0); bits[2:1] MODE.
- 0x04 OPA, RW: bits[15:0].
- 0x08 OPB, RW: bits[15:0].
- 0x0C RESULT, RO: captured 32-bit result.
- 0x10 STATUS, RO: bit0 BUSY, bit1 DONE.

Unused bits read 0. Writes to RO registers are ignored and respond OKAY.

Bus pipeline:
- The address phase latches `haddr[4:2]`, `hwrite` and a valid flag.
- Register writes take effect at the end of the data phase, using `hwdata`.

Illegal access (either condition triggers it):
- Offset > 0x10, or `haddr[1:0]` != 0.
- Response is a two-cycle ERROR: cycle 1 `hreadyout=0, hresp=1`; cycle 2 `hreadyout=1, hresp=1`.
- No register changes.

FSM states IDLE, CALC, DONE:
- IDLE -> CALC on a CTRL write with START=1. MODE is written in the same access.
- CALC lasts exactly one cycle. `ctrl=1` during CALC only. At the end of CALC, `result` is captured into RESULT, then DONE.
- DONE -> CALC on a new START.
- DONE -> IDLE after a completed read of RESULT.
- BUSY = (state==CALC). DONE bit = (state==DONE).

`clac_mode`, `opcode_a`, `opcode_b` are driven directly from the MODE, OPA and OPB registers. `ctrl=0` in every state except CALC.

Collisions:
- Any data phase that falls in a CALC cycle (a write to any register, or a read of RESULT/STATUS) gets one wait state (`hreadyout=0`). It completes in the following cycle using post-capture values.
- A START written while in CALC is therefore applied after capture. It re-enters CALC, and RESULT is overwritten on the next capture.

`hrdata`:
- Combinational mux on the latched data-phase address. It carries register data while a read data phase is valid and OKAY.
- It is 0 otherwise.

## Timing
Reset values (reset is asynchronous, active-high):
- `hreadyout=1`, `hresp=0`, `hrdata=0`.
- `ctrl=0`, `clac_mode=0`, `opcode_a=0`, `opcode_b=0`.
- RESULT=0, state IDLE, address-phase latch invalid.

START latency:
- START write data phase in cycle N.
- CALC in cycle N+1, with `ctrl=1`.
- RESULT valid, DONE=1 from cycle N+2.

Reads:
- A RESULT read whose address phase is at cycle N+1 completes at cycle N+2 with zero wait states, because its data phase follows capture.
- A read issued in the same beat as the START data phase has its data phase in CALC and gets one wait state.

Reset mid-CALC:
- Immediate return to IDLE, `ctrl=0`.
- RESULT=0, and no capture occurs.
- Any in-flight bus transfer is dropped.

Back-to-back transfers are supported with no idle cycles, except the stalls described above.

## Test plan
- Write OPA=0x00FF, OPB=0x0F0F, CTRL=0x1 (AND) -> `ctrl` high for exactly one cycle; RESULT read returns 0x0000000F; STATUS=0x2 before the read, 0x0 after.
- OPA=0xFFFF, OPB=0x0001, CTRL=0x7 (ADD) -> RESULT=0x00010000. Repeat with CTRL=0x5 (XOR) -> 0x0000FFFE.
- CTRL START write followed immediately by a back-to-back STATUS read -> that read takes one wait state and returns 0x2.
- Read at 0x14, and write at 0x06 -> two-cycle ERROR (`hreadyout` 0 then 1, `hresp=1`); registers unchanged.
- Assert `hrst` during the CALC cycle -> all outputs at their reset values that same cycle; a subsequent RESULT read returns 0.
- Write 0xABCD to RESULT, then read it -> value unchanged, OKAY response.
